cpu_sequencer: RTL and testbench

- Multi-cycle control unit for the master CPU.
- Replaces bench-driven instruction stepping: owns the program counter and fetches from the instruction RAM.
- Evaluates the condition field against registered flags and sequences memory_enable, data-RAM strobes and register write-back for each instruction.
- Sits between RAM_i/RAM and the Register_bank/memory_control/MASTER_ALU datapath.

---
 rtl/cpu_pkg.sv | 68 ++++++
 rtl/cond_eval.sv | 45 ++++
 rtl/cpu_sequencer.sv | 130 +++++++++++++
 tb/tb_cpu_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg: shared encodings for the master CPU control path.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_t;

  localparam logic [3:0] OP_LDR  = 4'hA;
  localparam logic [3:0] OP_STR  = 4'hB;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] COND_AL = 4'h0;
  localparam logic [3:0] COND_EQ = 4'h1;
  localparam logic [3:0] COND_NE = 4'h2;
  localparam logic [3:0] COND_CS = 4'h3;
  localparam logic [3:0] COND_CC = 4'h4;
  localparam logic [3:0] COND_MI = 4'h5;
  localparam logic [3:0] COND_PL = 4'h6;
  localparam logic [3:0] COND_VS = 4'h7;
  localparam logic [3:0] COND_VC = 4'h8;
  localparam logic [3:0] COND_HI = 4'h9;
  localparam logic [3:0] COND_LS = 4'hA;
  localparam logic [3:0] COND_GE = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GT = 4'hD;
  localparam logic [3:0] COND_LE = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Instruction word layout; a branch reuses the SHFT field as its target.
  localparam int COND_HI_B = 31;
  localparam int COND_LO_B = 28;
  localparam int OPC_HI_B  = 27;
  localparam int OPC_LO_B  = 24;
  localparam int S_B       = 23;
  localparam int DEST_HI_B = 22;
  localparam int DEST_LO_B = 19;
  localparam int SRC2_HI_B = 18;
  localparam int SRC2_LO_B = 15;
  localparam int SRC1_HI_B = 14;
  localparam int SRC1_LO_B = 11;
  localparam int SHFT_HI_B = 10;
  localparam int SHFT_LO_B = 3;
  localparam int MOV_HI_B  = 2;
  localparam int MOV_LO_B  = 0;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_mem_op(input logic [3:0] opc);
    return (opc == OP_LDR) || (opc == OP_STR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cond_eval.sv
// ----------------------------------------------------------------------------
// cond_eval: combinational condition-code check against NZCV.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = nzcv_i[FLAG_N];
  assign z = nzcv_i[FLAG_Z];
  assign c = nzcv_i[FLAG_C];
  assign v = nzcv_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_AL: pass_o = 1'b1;
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      default: pass_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// ----------------------------------------------------------------------------
// cpu_sequencer: multi-cycle fetch/decode/execute control unit.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              MEM_WAIT = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  output logic            Imem_en,
  output logic            Imem_rw,
  output logic [15:0]     Imem_addr,
  input  logic [31:0]     Imem_data,
  output logic [31:0]     Instr,
  input  logic [3:0]      Flag_in,
  output logic [3:0]      Flag,
  output logic            Mem_en,
  output logic            Dmem_en,
  output logic            Dmem_rw,
  output logic            Reg_we,
  output logic [PC_W-1:0] Pc,
  output logic            Busy,
  output logic            Halted
);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [3:0]        flag_q, flag_d;
  logic [3:0]        wait_q, wait_d;

  logic [3:0]        opc;
  logic              pass;

  assign opc = instr_q[OPC_HI_B:OPC_LO_B];

  // Flags only change at WRITEBACK, so one evaluator serves EXECUTE and WRITEBACK.
  cond_eval u_cond_eval (
    .cond_i (instr_q[COND_HI_B:COND_LO_B]),
    .nzcv_i (flag_q),
    .pass_o (pass)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      flag_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      flag_q  <= flag_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    flag_d  = flag_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        instr_d = Imem_data;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (pass && is_mem_op(opc))  state_d = ST_MEMORY;
        else if (pass && opc == OP_HALT) state_d = ST_HALT;
        else                         state_d = ST_WRITEBACK;
      end
      ST_MEMORY: begin
        if (wait_q == 4'(MEM_WAIT)) begin
          wait_d  = '0;
          state_d = ST_WRITEBACK;
        end else begin
          wait_d  = wait_q + 4'd1;
        end
      end
      ST_WRITEBACK: begin
        if (pass && instr_q[S_B]) flag_d = Flag_in;
        if (pass && opc == OP_B) pc_d = PC_W'(instr_q[SHFT_HI_B:SHFT_LO_B]);
        else                     pc_d = pc_q + PC_W'(1);
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    Imem_en = (state_q == ST_FETCH) || (state_q == ST_DECODE);
    Mem_en  = (state_q == ST_MEMORY);
    Dmem_en = (state_q == ST_MEMORY);
    Dmem_rw = (state_q == ST_MEMORY) && (opc == OP_LDR);
    Reg_we  = (state_q == ST_WRITEBACK) && pass &&
              (opc != OP_STR) && (opc != OP_B) && (opc != OP_HALT);
    Busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
    Halted  = (state_q == ST_HALT);
  end

  assign Imem_rw   = 1'b1;
  assign Imem_addr = 16'(pc_q);
  assign Instr     = instr_q;
  assign Flag      = flag_q;
  assign Pc        = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cpu_sequencer: directed table, corner sequences and random program run.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cpu_sequencer;

  localparam int MW = 1;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic        Imem_en, Imem_rw, Mem_en, Dmem_en, Dmem_rw, Reg_we, Busy, Halted;
  logic [15:0] Imem_addr;
  logic [31:0] Imem_data, Instr;
  logic [3:0]  Flag_in, Flag;
  logic [7:0]  Pc;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  cpu_sequencer #(.PC_W(8), .MEM_WAIT(MW), .RESET_PC(8'h00)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Imem_en(Imem_en), .Imem_rw(Imem_rw), .Imem_addr(Imem_addr), .Imem_data(Imem_data),
    .Instr(Instr), .Flag_in(Flag_in), .Flag(Flag),
    .Mem_en(Mem_en), .Dmem_en(Dmem_en), .Dmem_rw(Dmem_rw), .Reg_we(Reg_we),
    .Pc(Pc), .Busy(Busy), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  // Synchronous-read instruction RAM
  always @(posedge Clk) if (Imem_en) Imem_data <= mem[Imem_addr[7:0]];

  typedef struct {
    int cycles; int we_cnt; int we_cyc; int mem_cnt; int dmem_cnt;
    int rd_cnt; int busy_lo; bit halted; bit timeout;
  } obs_t;

  typedef struct {
    logic [31:0] instr; logic [3:0] fin; int cycles; int we; int mem;
    bit rd; logic [7:0] npc; logic [3:0] nflag;
  } vec_t;

  typedef struct {
    int cycles; int we; int mem; int rd; logic [7:0] npc; logic [3:0] nflag; bit halt;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return 1;        4'h1: return z;          4'h2: return !z;
      4'h3: return cy;       4'h4: return !cy;        4'h5: return n;
      4'h6: return !n;       4'h7: return v;          4'h8: return !v;
      4'h9: return cy && !z; 4'hA: return !cy || z;   4'hB: return n == v;
      4'hC: return n != v;   4'hD: return !z && (n == v);
      4'hE: return z || (n != v);
      default: return 0;
    endcase
  endfunction

  // Instruction-level outcome from the architectural rules
  function automatic exp_t predict(input logic [31:0] ins, input logic [3:0] f,
                                   input logic [7:0] pc, input logic [3:0] fin);
    exp_t e;
    bit p, memop;
    logic [3:0] op;
    op     = ins[27:24];
    p      = cond_ok(ins[31:28], f);
    memop  = p && (op == 4'hA || op == 4'hB);
    e.halt = p && (op == 4'hF);
    e.cycles = e.halt ? 3 : (memop ? 5 + MW : 4);
    e.mem    = memop ? MW + 1 : 0;
    e.rd     = (memop && op == 4'hA) ? MW + 1 : 0;
    e.we     = (p && !(op inside {4'hB, 4'hC, 4'hF})) ? 1 : 0;
    e.npc    = e.halt ? pc : ((p && op == 4'hC) ? ins[10:3] : pc + 8'd1);
    e.nflag  = (p && ins[23] && !e.halt) ? fin : f;
    return e;
  endfunction

  // Entered at the falling edge of a FETCH cycle; returns at the next FETCH or HALT.
  task automatic step(output obs_t o);
    bit prev;
    o = '{default: 0};
    o.cycles = 1;
    prev = 1'b1;
    if (!Busy) o.busy_lo++;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (Halted) begin o.halted = 1; return; end
      if (Imem_en && !prev) return;
      o.cycles++;
      prev = Imem_en;
      if (Reg_we) begin o.we_cnt++; o.we_cyc = o.cycles; end
      if (Mem_en)  o.mem_cnt++;
      if (Dmem_en) o.dmem_cnt++;
      if (Dmem_en && Dmem_rw) o.rd_cnt++;
      if (!Busy) o.busy_lo++;
    end
    o.timeout = 1;
  endtask

  task automatic do_reset();
    Reset = 1'b0; Start = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic do_start();
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
  endtask

  vec_t tbl[13];
  obs_t o;
  exp_t e;

  initial begin
    logic [7:0]  a, mpc;
    logic [3:0]  mfl, fin, op;
    logic [31:0] ins;
    int          wecnt;
    Reset = 1'b0; Start = 1'b0; Flag_in = 4'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0100_0000;

    tbl[0]  = '{32'h0100_0000, 4'h0, 4,      1, 0,      1'b0, 8'h01, 4'h0};
    tbl[1]  = '{32'h0A00_0000, 4'h0, 5 + MW, 1, MW + 1, 1'b1, 8'h02, 4'h0};
    tbl[2]  = '{32'h0B00_0000, 4'h0, 5 + MW, 0, MW + 1, 1'b0, 8'h03, 4'h0};
    tbl[3]  = '{32'h0180_0000, 4'h4, 4,      1, 0,      1'b0, 8'h04, 4'h4};
    tbl[4]  = '{32'h1C00_0100, 4'h0, 4,      0, 0,      1'b0, 8'h20, 4'h4};
    tbl[5]  = '{32'h0180_0000, 4'h0, 4,      1, 0,      1'b0, 8'h21, 4'h0};
    tbl[6]  = '{32'h1C00_0100, 4'h0, 4,      0, 0,      1'b0, 8'h22, 4'h0};
    tbl[7]  = '{32'h0180_0000, 4'h8, 4,      1, 0,      1'b0, 8'h23, 4'h8};
    tbl[8]  = '{32'hF180_0000, 4'h1, 4,      0, 0,      1'b0, 8'h24, 4'h8};
    tbl[9]  = '{32'hFA00_0000, 4'h0, 4,      0, 0,      1'b0, 8'h25, 4'h8};
    tbl[10] = '{32'hFF00_0000, 4'h0, 4,      0, 0,      1'b0, 8'h26, 4'h8};
    tbl[11] = '{32'h0C00_07F8, 4'h0, 4,      0, 0,      1'b0, 8'hFF, 4'h8};
    tbl[12] = '{32'h0100_0000, 4'h0, 4,      1, 0,      1'b0, 8'h00, 4'h8};
    a = 8'h00;
    for (int i = 0; i < 13; i++) begin mem[a] = tbl[i].instr; a = tbl[i].npc; end

    // Reset state
    repeat (3) @(negedge Clk);
    chk("reset_outputs",
        32'({Imem_en, Imem_rw, Mem_en, Dmem_en, Dmem_rw, Reg_we, Busy, Halted}), 32'h40);
    chk("reset_pc", 32'(Pc), 32'h0);
    chk("reset_flag", 32'(Flag), 32'h0);
    chk("reset_instr", Instr, 32'h0);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("idle_hold", 32'({Busy, Imem_en}), 32'h0);

    // Directed program
    do_start();
    for (int i = 0; i < 13; i++) begin
      Flag_in = tbl[i].fin;
      step(o);
      chk($sformatf("v%0d_timeout", i), 32'(o.timeout), 32'h0);
      chk($sformatf("v%0d_cycles", i), o.cycles, tbl[i].cycles);
      chk($sformatf("v%0d_reg_we", i), o.we_cnt, tbl[i].we);
      if (tbl[i].we != 0) chk($sformatf("v%0d_we_last", i), o.we_cyc, tbl[i].cycles);
      chk($sformatf("v%0d_mem_en", i), o.mem_cnt, tbl[i].mem);
      chk($sformatf("v%0d_dmem_en", i), o.dmem_cnt, tbl[i].mem);
      chk($sformatf("v%0d_dmem_rd", i), o.rd_cnt, tbl[i].rd ? tbl[i].mem : 0);
      chk($sformatf("v%0d_busy", i), o.busy_lo, 0);
      chk($sformatf("v%0d_pc", i), 32'(Pc), 32'(tbl[i].npc));
      chk($sformatf("v%0d_flag", i), 32'(Flag), 32'(tbl[i].nflag));
      if (o.timeout) break;
    end

    // HALT is terminal; Start is ignored
    do_reset();
    mem[0] = 32'h0F00_0000;
    do_start();
    step(o);
    chk("halt_reached", 32'(o.halted), 32'h1);
    chk("halt_cycles", o.cycles, 3);
    Start = 1'b1;
    repeat (3) @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    chk("halt_sticky", 32'({Halted, Busy, Imem_en, Reg_we}), 32'h8);
    chk("halt_pc", 32'(Pc), 32'h0);

    // Reset in the middle of MEMORY aborts the load
    do_reset();
    mem[0] = 32'h0A80_0000;
    Flag_in = 4'hF;
    do_start();
    repeat (3) @(negedge Clk);
    chk("mid_in_memory", 32'({Mem_en, Dmem_en}), 32'h3);
    Reset = 1'b0;
    wecnt = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (Reg_we) wecnt++;
      @(negedge Clk);
    end
    chk("mid_no_we", wecnt, 0);
    chk("mid_state", 32'({Busy, Mem_en, Dmem_en}), 32'h0);
    chk("mid_pc", 32'(Pc), 32'h0);
    chk("mid_flag", 32'(Flag), 32'h0);
    chk("mid_instr", Instr, 32'h0);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("mid_idle_after", 32'(Busy), 32'h0);

    // Random program against the instruction-level model
    do_reset();
    do_start();
    mpc = 8'h00; mfl = 4'h0;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 19))
        0, 1, 2:  op = 4'hA;
        3, 4, 5:  op = 4'hB;
        6, 7, 8:  op = 4'hC;
        9:        op = 4'hF;
        default:  op = 4'($urandom_range(0, 9));
      endcase
      ins = $urandom;
      ins[27:24] = op;
      mem[mpc] = ins;
      fin = 4'($urandom);
      Flag_in = fin;
      Start = 1'($urandom);
      e = predict(ins, mfl, mpc, fin);
      step(o);
      chk("rnd_timeout", 32'(o.timeout), 32'h0);
      chk("rnd_halt", 32'(o.halted), 32'(e.halt));
      chk("rnd_cycles", o.cycles, e.cycles);
      chk("rnd_we", o.we_cnt, e.we);
      chk("rnd_mem_en", o.mem_cnt, e.mem);
      chk("rnd_dmem_en", o.dmem_cnt, e.mem);
      chk("rnd_dmem_rd", o.rd_cnt, e.rd);
      chk("rnd_pc", 32'(Pc), 32'(e.npc));
      chk("rnd_flag", 32'(Flag), 32'(e.nflag));
      if (o.timeout) break;
      mpc = e.npc; mfl = e.nflag;
      if (e.halt) begin
        do_reset();
        do_start();
        mpc = 8'h00; mfl = 4'h0;
      end
    end
    Start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
